// File: rtl/fft_result_collector.sv
// ---------------------------------------------------------------------------
// fft_result_collector
//
// Watches the natural-order output stream of a 1024-point cfft and extracts
// two numbers per frame:
//   - DC_component : scaled magnitude of bin 0
//   - AC_component : scaled magnitude of the strongest bin in [BIN_LO, BIN_HI]
// Magnitudes use the alpha-max-plus-beta-min estimate max + min/2, and are
// reported as mag >> 3 (22 bits). One result set is published per complete
// frame of 1024 accepted samples, three clocks after the last sample.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   frame_start    one-cycle pulse, aborts any partial frame
//   fft_out_valid  one cfft output sample present this cycle
//   fft_out_pos    bin index of the sample (data only, not used for framing)
//   Iout, Qout     signed 24-bit real / imaginary parts
//   AC_component   scaled in-band peak magnitude (held between reports)
//   DC_component   scaled bin-0 magnitude (held between reports)
//   peak_bin       bin index of the in-band peak (held between reports)
//   new_comp_DV    one-cycle pulse when the three result outputs update
//   pdb_done       one-cycle pulse with new_comp_DV, releases upstream buffer
//   overrun        sticky: a valid sample arrived while flushing/reporting
// ---------------------------------------------------------------------------
module fft_result_collector #(
    parameter int BIN_LO = 13,
    parameter int BIN_HI = 77
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        fft_out_valid,
    input  logic [9:0]  fft_out_pos,
    input  logic [23:0] Iout,
    input  logic [23:0] Qout,
    output logic [21:0] AC_component,
    output logic [21:0] DC_component,
    output logic [9:0]  peak_bin,
    output logic        new_comp_DV,
    output logic        pdb_done,
    output logic        overrun
);

    localparam logic [9:0]  LO_BIN     = 10'(BIN_LO);
    localparam logic [9:0]  HI_BIN     = 10'(BIN_HI);
    localparam logic [10:0] LAST_COUNT = 11'd1023;

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, REPORT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [10:0] r_count;
    logic        r_flush_cnt;

    // vld_pipe[0] qualifies S1, vld_pipe[1] qualifies S2
    logic [1:0]  r_vld_pipe;
    logic [23:0] r_s1_abs_i;
    logic [23:0] r_s1_abs_q;
    logic [9:0]  r_s1_pos;
    logic [24:0] r_s2_mag;
    logic [9:0]  r_s2_pos;

    logic [24:0] r_peak_mag;
    logic [9:0]  r_peak_bin;
    logic [24:0] r_dc_mag;

    logic        w_accept;
    logic        w_drop;
    logic        w_last;
    logic [23:0] w_max;
    logic [23:0] w_min;
    logic        w_in_band;

    // Two's-complement magnitude; 0x800000 maps onto itself, which as an
    // unsigned value is exactly 8388608.
    function automatic logic [23:0] f_abs(input logic [23:0] x);
        return x[23] ? (~x + 24'd1) : x;
    endfunction

    // A frame_start that coincides with a valid makes that sample the first
    // of the new frame, whatever state the collector was in.
    assign w_accept = fft_out_valid &&
                      (frame_start || r_state == IDLE || r_state == COLLECT);
    assign w_drop   = fft_out_valid && !frame_start &&
                      (r_state == FLUSH || r_state == REPORT);
    assign w_last   = !frame_start && fft_out_valid &&
                      r_state == COLLECT && r_count == LAST_COUNT;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = fft_out_valid ? COLLECT : IDLE;
        end else begin
            case (r_state)
                IDLE:    if (fft_out_valid) w_state_nxt = COLLECT;
                COLLECT: if (w_last)        w_state_nxt = FLUSH;
                FLUSH:   if (r_flush_cnt)   w_state_nxt = REPORT;
                REPORT:                     w_state_nxt = IDLE;
                default:                    w_state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_flush_cnt <= 1'b0;
        end else begin
            if (frame_start || r_state == IDLE)
                r_count <= fft_out_valid ? 11'd1 : 11'd0;
            else if (r_state == COLLECT && fft_out_valid)
                r_count <= r_count + 11'd1;
            // toggles 0 -> 1 -> 0 across the two FLUSH cycles
            r_flush_cnt <= (r_state == FLUSH) && !frame_start && !r_flush_cnt;
        end
    end

    // ---------------- S1 / S2 ----------------
    assign w_max = (r_s1_abs_i >= r_s1_abs_q) ? r_s1_abs_i : r_s1_abs_q;
    assign w_min = (r_s1_abs_i >= r_s1_abs_q) ? r_s1_abs_q : r_s1_abs_i;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_s1_abs_i <= '0;
            r_s1_abs_q <= '0;
            r_s1_pos   <= '0;
            r_s2_mag   <= '0;
            r_s2_pos   <= '0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            r_vld_pipe[1] <= r_vld_pipe[0] && !frame_start;
            if (w_accept) begin
                r_s1_abs_i <= f_abs(Iout);
                r_s1_abs_q <= f_abs(Qout);
                r_s1_pos   <= fft_out_pos;
            end
            r_s2_mag <= {1'b0, w_max} + {1'b0, (w_min >> 1)};
            r_s2_pos <= r_s1_pos;
        end
    end

    // ---------------- S3: running DC / peak ----------------
    assign w_in_band = (r_s2_pos >= LO_BIN) && (r_s2_pos <= HI_BIN);

    always_ff @(posedge clk) begin
        if (!reset_n || frame_start || r_state == IDLE) begin
            r_peak_mag <= '0;
            r_peak_bin <= LO_BIN;
            r_dc_mag   <= '0;
        end else if (r_vld_pipe[1]) begin
            if (r_s2_pos == 10'd0)
                r_dc_mag <= r_s2_mag;
            // strict compare: equal later bins never displace the first
            if (w_in_band && r_s2_mag > r_peak_mag) begin
                r_peak_mag <= r_s2_mag;
                r_peak_bin <= r_s2_pos;
            end
        end
    end

    // ---------------- outputs ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            AC_component <= '0;
            DC_component <= '0;
            peak_bin     <= '0;
            new_comp_DV  <= 1'b0;
            pdb_done     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            new_comp_DV <= 1'b0;
            pdb_done    <= 1'b0;
            if (r_state == REPORT && !frame_start) begin
                AC_component <= r_peak_mag[24:3];
                DC_component <= r_dc_mag[24:3];
                peak_bin     <= r_peak_bin;
                new_comp_DV  <= 1'b1;
                pdb_done     <= 1'b1;
            end
            if (w_drop)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_result_collector.sv
module tb_fft_result_collector;

    localparam int LO = 13;
    localparam int HI = 77;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        fft_out_valid = 1'b0;
    logic [9:0]  fft_out_pos = '0;
    logic [23:0] Iout = '0;
    logic [23:0] Qout = '0;
    logic [21:0] AC_component;
    logic [21:0] DC_component;
    logic [9:0]  peak_bin;
    logic        new_comp_DV;
    logic        pdb_done;
    logic        overrun;

    fft_result_collector #(.BIN_LO(LO), .BIN_HI(HI)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .fft_out_valid(fft_out_valid),
        .fft_out_pos  (fft_out_pos),
        .Iout         (Iout),
        .Qout         (Qout),
        .AC_component (AC_component),
        .DC_component (DC_component),
        .peak_bin     (peak_bin),
        .new_comp_DV  (new_comp_DV),
        .pdb_done     (pdb_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int I_arr [1024];
    int Q_arr [1024];
    int exp_ac, exp_dc, exp_bin;
    int n_chk = 0;
    int n_pass = 0;
    int dv_cnt = 0;
    int pdb_cnt = 0;
    int coinc_err = 0;
    int exp_dv = 0;

    always @(negedge clk) begin
        if (new_comp_DV === 1'b1) dv_cnt++;
        if (pdb_done === 1'b1) pdb_cnt++;
        if (new_comp_DV !== pdb_done) coinc_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: magnitude = larger + smaller/2, DC from bin 0, AC is the
    // first-seen strictly largest in-band magnitude, both reported /8.
    function automatic void model();
        int best, bbin, dc;
        best = 0; bbin = LO; dc = 0;
        for (int p = 0; p < 1024; p++) begin
            int a, b, m;
            a = iabs(I_arr[p]);
            b = iabs(Q_arr[p]);
            m = (a > b) ? a + b / 2 : b + a / 2;
            if (p == 0) dc = m;
            if (p >= LO && p <= HI && m > best) begin
                best = m;
                bbin = p;
            end
        end
        exp_ac  = best / 8;
        exp_dc  = dc / 8;
        exp_bin = bbin;
    endfunction

    function automatic void clear_frame();
        for (int p = 0; p < 1024; p++) begin
            I_arr[p] = 0;
            Q_arr[p] = 0;
        end
    endfunction

    function automatic int rnd24();
        return int'($urandom_range(0, 32'hFFFFFF)) - 8388608;
    endfunction

    // mode 0: full range, 1: tiny values (many ties), 2: sparse
    function automatic void fill_random(input int mode);
        for (int p = 0; p < 1024; p++) begin
            case (mode)
                0: begin I_arr[p] = rnd24(); Q_arr[p] = rnd24(); end
                1: begin
                    I_arr[p] = int'($urandom_range(0, 15)) - 8;
                    Q_arr[p] = int'($urandom_range(0, 15)) - 8;
                end
                default: begin
                    I_arr[p] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 200000)) - 100000 : 0;
                    Q_arr[p] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 200000)) - 100000 : 0;
                end
            endcase
        end
    endfunction

    // Drives one full frame of 1024 samples, then checks result timing and
    // values. Inputs change on the falling edge; outputs sampled there too.
    task automatic run_frame(input string tag, input int gapmax, input bit fs_first, input bit ovr);
        model();
        for (int i = 0; i < 1024; i++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            fft_out_valid = 1'b0;
            repeat (g) @(negedge clk);
            fft_out_valid = 1'b1;
            fft_out_pos   = 10'(i);
            Iout          = 24'(I_arr[i]);
            Qout          = 24'(Q_arr[i]);
            frame_start   = (i == 0) && fs_first;
            @(negedge clk);
            frame_start   = 1'b0;
        end
        fft_out_valid = 1'b0;
        if (ovr) begin
            // lands in the first FLUSH cycle; must be dropped
            fft_out_valid = 1'b1;
            fft_out_pos   = 10'd20;
            Iout          = 24'h7FFFFF;
            Qout          = 24'h7FFFFF;
        end
        @(negedge clk);
        fft_out_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_dv_early"}, new_comp_DV, 1'b0);
        @(negedge clk);
        chk({tag, "_dv"}, new_comp_DV, 1'b1);
        chk({tag, "_pdb"}, pdb_done, 1'b1);
        chk({tag, "_ac"}, AC_component, exp_ac);
        chk({tag, "_dc"}, DC_component, exp_dc);
        chk({tag, "_bin"}, peak_bin, exp_bin);
        if (ovr) chk({tag, "_overrun"}, overrun, 1'b1);
        exp_dv++;
        @(negedge clk);
        chk({tag, "_dv_pulse"}, new_comp_DV, 1'b0);
    endtask

    // Partial frame with large in-band and bin-0 values that must never show.
    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            fft_out_valid = 1'b1;
            fft_out_pos   = 10'(i);
            Iout          = (i == 0 || i == 20) ? 24'h7FFFFF : 24'(rnd24());
            Qout          = 24'h0;
            @(negedge clk);
        end
        fft_out_valid = 1'b0;
    endtask

    initial begin
        // ---- reset with valid toggling ----
        reset_n = 1'b0;
        repeat (8) begin
            @(negedge clk);
            fft_out_valid = ~fft_out_valid;
            fft_out_pos   = 10'($urandom_range(0, 1023));
            Iout          = 24'($urandom);
        end
        fft_out_valid = 1'b0;
        @(negedge clk);
        chk("rst_ac", AC_component, 0);
        chk("rst_dc", DC_component, 0);
        chk("rst_bin", peak_bin, 0);
        chk("rst_dv", new_comp_DV, 0);
        chk("rst_pdb", pdb_done, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_dvcnt", dv_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---- basic frame ----
        clear_frame();
        I_arr[0] = 8000;
        I_arr[20] = 3000; Q_arr[20] = 4000;
        run_frame("basic", 0, 0, 0);
        chk("basic_dc_abs", DC_component, 1000);
        chk("basic_ac_abs", AC_component, 687);
        repeat (20) @(negedge clk);
        chk("hold_ac", AC_component, exp_ac);
        chk("hold_bin", peak_bin, exp_bin);
        chk("hold_dvcnt", dv_cnt, exp_dv);

        // ---- out-of-band peak plus tie ----
        clear_frame();
        I_arr[5] = 4000000; I_arr[30] = -800; Q_arr[40] = 800;
        run_frame("tie", 2, 0, 0);
        chk("tie_ac_abs", AC_component, 100);
        chk("tie_bin_abs", peak_bin, 30);

        // ---- extremes ----
        clear_frame();
        I_arr[0] = -8388608; Q_arr[0] = -8388608;
        I_arr[77] = -8388608; Q_arr[77] = -8388608;
        I_arr[78] = -8388608; Q_arr[78] = -8388608;
        run_frame("ext", 1, 0, 0);
        chk("ext_dc_abs", DC_component, 1572864);
        chk("ext_ac_abs", AC_component, 1572864);
        clear_frame();
        I_arr[77] = 100;
        I_arr[78] = -8388608; Q_arr[78] = -8388608;
        I_arr[12] = 8388607;
        run_frame("edge", 0, 0, 0);
        chk("edge_bin_abs", peak_bin, 77);

        // ---- abort after 500 samples ----
        send_partial(500);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_hold_ac", AC_component, exp_ac);
        chk("abort_hold_bin", peak_bin, exp_bin);
        chk("abort_no_dv", dv_cnt, exp_dv);
        clear_frame();
        I_arr[50] = 1600;
        run_frame("abort", 1, 0, 0);
        chk("abort_ac_abs", AC_component, 200);
        chk("abort_bin_abs", peak_bin, 50);

        // ---- abort with frame_start on the first sample of the new frame ----
        send_partial(300);
        fill_random(2);
        run_frame("fsv", 1, 1, 0);

        // ---- reset mid-frame ----
        send_partial(600);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_ac", AC_component, 0);
        chk("midrst_bin", peak_bin, 0);
        repeat (4) @(negedge clk);
        chk("midrst_no_dv", dv_cnt, exp_dv);
        fill_random(0);
        run_frame("postrst", 0, 0, 0);

        // ---- overrun ----
        chk("ovr_pre", overrun, 0);
        fill_random(2);
        run_frame("ovr", 1, 0, 1);

        // ---- random frames ----
        for (int k = 0; k < 4; k++) begin
            fill_random(k % 3);
            run_frame($sformatf("rnd%0d", k), k, 0, 0);
        end
        chk("ovr_sticky", overrun, 1);

        repeat (5) @(negedge clk);
        chk("dv_total", dv_cnt, exp_dv);
        chk("pdb_total", pdb_cnt, exp_dv);
        chk("dv_pdb_coinc", coinc_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_result_collector.md
FFT_RESULT_COLLECTOR -- requirements
Module: fft_result_collector

Interface
REQ-001 SHALL have parameter BIN_LO, default 13, meaning the lowest bin index searched for the AC peak (0.5 Hz at 40 sps, 1024 points).
REQ-002 SHALL have parameter BIN_HI, default 77, meaning the highest bin index searched for the AC peak (3.0 Hz).
REQ-003 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port frame_start, input, 1, one-cycle pulse (the same pulse that starts the cfft); aborts any partial frame.
REQ-006 SHALL have port fft_out_valid, input, 1, the cfft output data enable; marks one output sample.
REQ-007 SHALL have port fft_out_pos, input, 10, the bin index of the current sample, in natural order.
REQ-008 SHALL have port Iout, input, 24, the signed two's-complement real part.
REQ-009 SHALL have port Qout, input, 24, the signed two's-complement imaginary part.
REQ-010 SHALL have port AC_component, output, 22, the scaled peak in-band magnitude.
REQ-011 SHALL have port DC_component, output, 22, the scaled bin-0 magnitude.
REQ-012 SHALL have port peak_bin, output, 10, the bin index of the AC peak.
REQ-013 SHALL have port new_comp_DV, output, 1, a one-cycle pulse when the result outputs update.
REQ-014 SHALL have port pdb_done, output, 1, a one-cycle pulse coincident with new_comp_DV; releases the upstream buffer.
REQ-015 SHALL have port overrun, output, 1, a sticky flag for valid samples dropped in FLUSH or REPORT.

Function
REQ-016 SHALL run a 3-stage pipeline:
- S1 registers |Iout| and |Qout| as 24-bit unsigned values, plus pos and valid; |-8388608| = 8388608.
- S2 registers mag = max + (min >> 1), 25 bits unsigned, no truncation before the sum.
- S3 compares and updates.
REQ-017 SHALL scale each magnitude to 22 bits as mag[24:2] >> 1, i.e. mag >> 3; the result cannot overflow, so no saturation is applied.
REQ-018 SHALL use four states: IDLE, COLLECT, FLUSH, REPORT; reset enters IDLE.
REQ-019 SHALL, in IDLE, clear the sample count, running peak, peak index and DC register; the first accepted fft_out_valid moves to COLLECT.
REQ-020 SHALL, in COLLECT, count every accepted valid sample (11-bit counter); valid gaps of any length are allowed.
REQ-021 SHALL, on acceptance of the 1024th sample, go COLLECT -> FLUSH; FLUSH lasts 2 cycles to drain S1/S2, then goes to REPORT.
REQ-022 SHALL, in REPORT, load AC_component, DC_component and peak_bin, pulse new_comp_DV and pdb_done high for 1 cycle, then return to IDLE.
REQ-023 SHALL give a latency from the 1024th valid edge to the DV-high cycle of exactly 3 clk.
REQ-024 SHALL, in S3, load a sample with pos == 0 into the DC register.
REQ-025 SHALL, in S3, replace the running peak with a sample only when BIN_LO <= pos <= BIN_HI and mag > running peak (strict), so ties keep the first-seen bin.
REQ-026 SHALL report AC = 0 and peak_bin = BIN_LO if no in-band sample is non-zero.
REQ-027 SHALL hold outputs between reports.
REQ-028 SHALL, on frame_start in any state, return to IDLE and discard pipeline and partial results, with no DV pulse; held outputs are unchanged.
REQ-029 SHALL, when frame_start and fft_out_valid occur together, treat the sample as the first sample of a new frame.
REQ-030 SHALL ignore fft_out_valid during FLUSH and REPORT and set overrun; overrun clears only on reset.
REQ-031 SHALL treat fft_out_pos values as data only; frame completion depends solely on the count.

Reset
REQ-032 SHALL, while reset_n = 0 at a clk edge, set the state to IDLE and zero AC_component, DC_component, peak_bin, new_comp_DV, pdb_done, overrun, the counters and the pipeline valids.
REQ-033 SHALL, on reset mid-frame or mid-FLUSH, produce no DV pulse; the next complete frame reports normally.

Verification
REQ-034 SHALL cover the reset check: apply reset -> all outputs 0; hold reset with valid toggling -> no DV.
REQ-035 SHALL cover a basic frame: 1024 samples, bin0 I=8000 Q=0, bin20 I=3000 Q=4000, others 0 -> DC=1000, AC=687 (mag 5500), peak_bin=20, one DV and one pdb_done exactly 3 cycles after the last valid.
REQ-036 SHALL cover an out-of-band peak plus a tie: bin5 I=4000000, bin30 I=-800, bin40 Q=800 -> AC=100, peak_bin=30.
REQ-037 SHALL cover extremes: bin0 I=-8388608 Q=-8388608 -> DC=1572864; bin77 same -> AC=1572864, peak_bin=77; bin78 larger -> ignored.
REQ-038 SHALL cover abort: frame_start after 500 samples, then a full frame with bin50 I=1600 -> no DV for the aborted frame, then AC=200, peak_bin=50.
REQ-039 SHALL cover overrun: valid asserted during FLUSH -> overrun=1 and stays 1, and the report still matches the 1024-sample frame.
